// File: rtl/conv_mem_host.sv
// rtl/conv_mem_host.sv - image/layer-bank memory host for a convolution engine
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   start                      begins an image load (from IDLE or DONE)
//   ld_valid/ld_last/ld_addr/ld_data   image load stream
//   ready, busy                handshake with CONV (ready in READY, busy from CONV)
//   iaddr -> idata             registered image read during RUN
//   crd/cwr/csel/caddr_rd/caddr_wr/cdata_wr -> cdata_rd   layer bank access in RUN
//   done, wr_seen, err, timeout   completion pulse and status flags
//   dbg_sel/dbg_addr -> dbg_data  readback of image and banks in DONE
module conv_mem_host #(
   parameter int DW      = 20,
   parameter int TIMEOUT = 1000000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ld_valid,
   input  logic          ld_last,
   input  logic [11:0]   ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ready,
   input  logic          busy,
   input  logic [11:0]   iaddr,
   output logic [DW-1:0] idata,
   input  logic          crd,
   input  logic          cwr,
   input  logic [2:0]    csel,
   input  logic [11:0]   caddr_rd,
   input  logic [11:0]   caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   output logic [DW-1:0] cdata_rd,
   output logic          done,
   output logic [4:0]    wr_seen,
   output logic          err,
   output logic          timeout,
   input  logic [2:0]    dbg_sel,
   input  logic [11:0]   dbg_addr,
   output logic [DW-1:0] dbg_data
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READY, S_RUN, S_DONE} state_t;

   state_t state, state_nxt;

   logic [DW-1:0] img_mem [0:4095];
   logic [DW-1:0] l00_mem [0:4095];
   logic [DW-1:0] l01_mem [0:4095];
   logic [DW-1:0] l10_mem [0:1023];
   logic [DW-1:0] l11_mem [0:1023];
   logic [DW-1:0] l2_mem  [0:2047];

   logic [CW-1:0] cyc_cnt;
   logic [DW-1:0] idata_q;
   logic          in_run, cnt_hit, rd_ok, wr_ok, wr_en, proto_err, load_entry;

   // Layer bank selects only (000 is the image, which CONV may not address here).
   function automatic logic addr_ok(input logic [2:0] sel, input logic [11:0] a);
      case (sel)
         3'b001, 3'b010: addr_ok = 1'b1;
         3'b011, 3'b100: addr_ok = (a[11:10] == 2'b00);
         3'b101:         addr_ok = ~a[11];
         default:        addr_ok = 1'b0;
      endcase
   endfunction

   // Shared read mux: 000 reaches the image; out-of-range or unused selects give 0.
   function automatic logic [DW-1:0] mem_rd(input logic [2:0] sel, input logic [11:0] a);
      mem_rd = '0;
      case (sel)
         3'b000: mem_rd = img_mem[a];
         3'b001: mem_rd = l00_mem[a];
         3'b010: mem_rd = l01_mem[a];
         3'b011: if (a[11:10] == 2'b00) mem_rd = l10_mem[a[9:0]];
         3'b100: if (a[11:10] == 2'b00) mem_rd = l11_mem[a[9:0]];
         3'b101: if (!a[11])            mem_rd = l2_mem[a[10:0]];
         default: mem_rd = '0;
      endcase
   endfunction

   assign in_run     = (state == S_RUN);
   assign cnt_hit    = (cyc_cnt == CW'(TIMEOUT - 1));
   assign rd_ok      = addr_ok(csel, caddr_rd);
   assign wr_ok      = addr_ok(csel, caddr_wr);
   assign wr_en      = in_run && cwr && wr_ok && !reset;
   assign proto_err  = (crd || cwr) && (!in_run || (crd && !rd_ok) || (cwr && !wr_ok));
   assign load_entry = (state_nxt == S_LOAD) && (state != S_LOAD);
   assign ready      = (state == S_READY);
   assign idata      = in_run ? idata_q : '0;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start)                state_nxt = S_LOAD;
         S_LOAD:  if (ld_valid && ld_last)  state_nxt = S_READY;
         S_READY: if (busy)                 state_nxt = S_RUN;
         S_RUN:   if (!busy || cnt_hit)     state_nxt = S_DONE;
         S_DONE:  if (start)                state_nxt = S_LOAD;
         default:                           state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_cnt  <= '0;
         idata_q  <= '0;
         cdata_rd <= '0;
         dbg_data <= '0;
         done     <= 1'b0;
         wr_seen  <= '0;
         err      <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         done     <= in_run && (state_nxt == S_DONE);
         // Held at zero outside RUN, so it starts from zero on every RUN entry.
         cyc_cnt  <= in_run ? cyc_cnt + 1'b1 : '0;
         idata_q  <= in_run ? img_mem[iaddr] : '0;
         if (in_run && crd)
            cdata_rd <= rd_ok ? mem_rd(csel, caddr_rd) : '0;
         dbg_data <= (state == S_DONE) ? mem_rd(dbg_sel, dbg_addr) : '0;
         if (load_entry) begin
            wr_seen <= '0;
            err     <= 1'b0;
            timeout <= 1'b0;
         end else begin
            if (proto_err)                  err     <= 1'b1;
            if (wr_en)                      wr_seen <= wr_seen | (5'b00001 << (csel - 3'd1));
            // A normal finish (busy low) on the last allowed cycle is not a timeout.
            if (in_run && busy && cnt_hit)  timeout <= 1'b1;
         end
      end
   end

   // Memories have no reset; contents survive a mid-run reset.
   always_ff @(posedge clk) begin
      if (state == S_LOAD && ld_valid && !reset)
         img_mem[ld_addr] <= ld_data;
      if (wr_en) begin
         case (csel)
            3'b001:  l00_mem[caddr_wr]        <= cdata_wr;
            3'b010:  l01_mem[caddr_wr]        <= cdata_wr;
            3'b011:  l10_mem[caddr_wr[9:0]]   <= cdata_wr;
            3'b100:  l11_mem[caddr_wr[9:0]]   <= cdata_wr;
            3'b101:  l2_mem[caddr_wr[10:0]]   <= cdata_wr;
            default: ;
         endcase
      end
   end

endmodule
